// File: rtl/hsv_core_pkg.sv
// Shared types and constants for the core issue/commit path.
package hsv_core_pkg;

    localparam int ORDER_DEPTH_DEFAULT = 4;
    localparam int NUM_EXEC_UNITS      = 4;

    // Values double as the bit index into the per-unit handshake vectors.
    typedef enum logic [1:0] {
        EXEC_ALU         = 2'd0,
        EXEC_MEM         = 2'd1,
        EXEC_BRANCH      = 2'd2,
        EXEC_CTRL_STATUS = 2'd3
    } exec_unit_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
    } execute_data_t;

    typedef struct packed {
        logic [31:0] pc;
    } commit_data_t;

endpackage

// File: rtl/hsv_core_issue_sched_if.sv
// Handshake bundle between decode, the execution units, commit and the scheduler.
interface hsv_core_issue_sched_if;
    import hsv_core_pkg::*;

    logic                                 issue_valid;
    logic                                 issue_ready;
    execute_data_t                        issue_data;
    exec_unit_t                           issue_unit;

    execute_data_t                        unit_data;
    logic [NUM_EXEC_UNITS-1:0]            unit_valid;
    logic [NUM_EXEC_UNITS-1:0]            unit_ready;

    logic [NUM_EXEC_UNITS-1:0]            done_valid;
    logic [NUM_EXEC_UNITS-1:0][31:0]      done_pc;
    logic [NUM_EXEC_UNITS-1:0]            done_ready;

    logic                                 commit_valid;
    logic                                 commit_ready;
    commit_data_t                         commit_data;
    exec_unit_t                           commit_unit;

    // Environment side: decode, execution units and commit stage.
    modport master (
        output issue_valid, issue_data, issue_unit, unit_ready,
               done_valid, done_pc, commit_ready,
        input  issue_ready, unit_data, unit_valid, done_ready,
               commit_valid, commit_data, commit_unit
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_data, issue_unit, unit_ready,
               done_valid, done_pc, commit_ready,
        output issue_ready, unit_data, unit_valid, done_ready,
               commit_valid, commit_data, commit_unit
    );

endinterface

// File: rtl/hsv_core_order_fifo.sv
// Program-order FIFO of target units; the head names the unit allowed to retire next.
module hsv_core_order_fifo
    import hsv_core_pkg::*;
#(
    parameter int DEPTH = ORDER_DEPTH_DEFAULT
) (
    input  logic       clk_core,
    input  logic       rst_core,
    input  logic       flush,
    input  logic       push,
    input  exec_unit_t push_unit,
    input  logic       pop,
    output exec_unit_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    exec_unit_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; validity is tracked by count, so stale entries are never observed.
    always_ff @(posedge clk_core) begin
        if (push) mem[wr_ptr] <= push_unit;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/hsv_core_issue_sched.sv
// Issue scheduler: one-entry dispatch register toward the units and in-order commit gating.
module hsv_core_issue_sched
    import hsv_core_pkg::*;
#(
    parameter int ORDER_DEPTH = ORDER_DEPTH_DEFAULT
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  flush,
    hsv_core_issue_sched_if.slave bus
);

    logic          hold_valid;
    execute_data_t hold_data;
    exec_unit_t    hold_unit;

    logic          dispatch_fire;
    logic          issue_fire;
    logic          commit_fire;
    logic          fifo_full;
    logic          fifo_empty;
    exec_unit_t    head_unit;

    // Issue readiness depends only on registered state plus the unit accepting the held entry,
    // so commit_ready/done_valid never reach issue_ready combinationally.
    assign dispatch_fire   = hold_valid && bus.unit_ready[hold_unit];
    assign bus.issue_ready = !rst_core && !flush && (!hold_valid || dispatch_fire) && !fifo_full;
    assign issue_fire      = bus.issue_valid && bus.issue_ready;
    assign commit_fire     = bus.commit_valid && bus.commit_ready;
    assign bus.unit_data   = hold_data;

    // Hold-register occupancy: load on accept, free on dispatch, clear on reset or flush.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            hold_valid <= 1'b0;
        end else if (issue_fire) begin
            hold_valid <= 1'b1;
        end else if (dispatch_fire) begin
            hold_valid <= 1'b0;
        end
    end

    // Held payload only changes on accept, keeping it stable while the target unit stalls.
    always_ff @(posedge clk_core) begin
        if (issue_fire) begin
            hold_data <= bus.issue_data;
            hold_unit <= bus.issue_unit;
        end
    end

    // Per-unit dispatch request and in-order commit handshakes.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        bus.unit_valid   = '0;
        bus.done_ready   = '0;
        bus.commit_valid = 1'b0;
        bus.commit_data  = '0;
        bus.commit_unit  = head_unit;

        if (!rst_core && hold_valid) begin
            bus.unit_valid[hold_unit] = 1'b1;
        end

        bus.commit_data.pc = bus.done_pc[head_unit];
        if (!rst_core && !flush && !fifo_empty) begin
            bus.commit_valid          = bus.done_valid[head_unit];
            bus.done_ready[head_unit] = bus.commit_ready;
        end
    end

    hsv_core_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .flush     (flush),
        .push      (issue_fire),
        .push_unit (bus.issue_unit),
        .pop       (commit_fire),
        .head      (head_unit),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/hsv_core_issue_sched.md
HSV_CORE_ISSUE_SCHED -- requirements
Module: hsv_core_issue_sched

Interface
REQ-001 Parameter ORDER_DEPTH, default 4, power of two >= 2: maximum instructions in flight between issue acceptance and commit.
REQ-002 clk_core  input  1  single core clock; all state changes on its rising edge.
REQ-003 rst_core  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all in-flight state.
REQ-005 issue_valid  input  1  issue_data/issue_unit are valid.
REQ-006 issue_ready  output  1  scheduler accepts an instruction this cycle.
REQ-007 issue_data  input  execute_data_t  decoded execute payload for all units.
REQ-008 issue_unit  input  exec_unit_t (2)  target execution unit.
REQ-009 unit_data  output  execute_data_t  held payload, broadcast to all units.
REQ-010 unit_valid  output  4  one-hot dispatch request, index = exec_unit_t.
REQ-011 unit_ready  input  4  per-unit accept.
REQ-012 done_valid  input  4  per-unit completion available.
REQ-013 done_pc  input  4x32  per-unit completed PC.
REQ-014 done_ready  output  4  per-unit completion consumed.
REQ-015 commit_valid  output  1  in-order commit available.
REQ-016 commit_ready  input  1  commit stage accepts.
REQ-017 commit_data  output  commit_data_t  committed PC.
REQ-018 commit_unit  output  exec_unit_t  unit that produced the commit.

Function
REQ-019 Dispatch: one-entry output register (hold_valid, hold_data, hold_unit); unit_data = hold_data at all times.
REQ-020 unit_valid[i] = hold_valid && hold_unit == i; at most one bit high; dispatch fires when unit_valid[i] && unit_ready[i].
REQ-021 issue_ready = !flush && (!hold_valid || dispatch fire) && inflight_count < ORDER_DEPTH, using registered count only (no combinational path from commit_ready or done_valid).
REQ-022 Issue accept (issue_valid && issue_ready): hold register loads next cycle; issue_unit is pushed into the order FIFO the same edge.
REQ-023 Held payload and unit SHALL remain stable while hold_valid && !unit_ready[hold_unit]; dispatch and accept on one cycle gives back-to-back issue with zero bubbles.
REQ-024 Order FIFO: ORDER_DEPTH entries of exec_unit_t, read/write pointers wrap modulo ORDER_DEPTH, inflight_count 0..ORDER_DEPTH.
REQ-025 Commit: head = FIFO head unit; commit_valid = count != 0 && done_valid[head] && !flush; commit_data.pc = done_pc[head]; commit_unit = head.
REQ-026 done_ready[head] = count != 0 && commit_ready && !flush; all other done_ready bits 0; completions from non-head units are held off (in-order retirement).
REQ-027 Commit fire (commit_valid && commit_ready) pops FIFO next edge; simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-028 Commit latency: combinational from done_valid[head] to commit_valid (0 cycles); minimum issue-to-commit latency = 1 cycle plus unit latency.
REQ-029 Full: count == ORDER_DEPTH forces issue_ready 0 even if a pop occurs that cycle. Empty: commit_valid 0 regardless of done_valid.
REQ-030 flush: in the flush cycle issue_ready, commit_valid and done_ready are 0; next edge clears hold_valid, pointers and count; issue_data presented during flush is dropped.
REQ-031 flush and rst_core asserted together: reset behaviour applies.

Reset
REQ-032 On rst_core high at a clock edge: hold_valid=0, pointers=0, count=0; unit_valid=0, issue_ready=0 during reset, commit_valid=0, done_ready=0.
REQ-033 Reset mid-operation discards held and in-flight entries; issue_ready returns to 1 the first cycle after reset deasserts.

Structure
REQ-034 exec_unit_t enum (EXEC_ALU=0, EXEC_MEM=1, EXEC_BRANCH=2, EXEC_CTRL_STATUS=3) and ORDER_DEPTH default constant belong in hsv_core_pkg alongside execute_data_t and commit_data_t.
REQ-035 Order FIFO is one sub-module, hsv_core_order_fifo (push/pop/full/empty/head, synchronous flush), parameterised on depth.

Verification
REQ-036 Issue ALU pc=0x100, unit_ready[0]=1 each cycle for 4 back-to-back issues -> unit_valid=0001 on 4 consecutive cycles, no bubbles.
REQ-037 Issue MEM pc=0x200 then ALU pc=0x204; ALU done first -> done_ready[0]=0 until MEM done; commit order 0x200, 0x204.
REQ-038 ORDER_DEPTH=4, 4 issues, no completions -> issue_ready=0 at count 4; one commit -> issue_ready=1 next cycle.
REQ-039 Hold BRANCH with unit_ready[2]=0 for 5 cycles -> unit_data stable, issue_ready=0, then dispatch on ready.
REQ-040 flush with 3 in flight and done_valid high -> no commit in flush cycle; next cycle count=0, unit_valid=0, commit_valid=0.
REQ-041 rst_core asserted with 2 in flight -> all outputs at reset values; new issue accepted the first cycle after release.
